// File: rtl/dot_feeder_pkg.sv
// Shared types and constants for the dot-product row feeder.
package dot_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ENG_RST,
    S_LAUNCH,
    S_WAIT_FIN,
    S_OUTPUT
  } state_t;

  // IEEE-754 single-precision constants
  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_TWO     = 32'h40000000;
  localparam logic [31:0] FP_SIXTEEN = 32'h41800000;

  // Width of a down-counter able to hold the largest of the three loads
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dot_feeder_timer.sv
// Loadable down-counter with zero flag; holds at zero.
module dot_feeder_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_dec && (r_count != '0))
      r_count <= r_count - W'(1);
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dot_product_row_feeder.sv
// Sequencer feeding matrix rows and a latched vector into the dot-product
// engine, emitting one scalar result per row on a valid/ready stream.
module dot_product_row_feeder
  import dot_feeder_pkg::*;
#(
  parameter int NI         = 8,
  parameter int ADDR_W     = 10,
  parameter int ROW_W      = 10,
  parameter int MEM_LAT    = 1,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_W-1:0]    num_rows,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [32*NI-1:0]    vector_in,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [32*NI-1:0]    mem_rd_data,
  output logic                eng_reset,
  output logic [32*NI-1:0]    eng_first_row,
  output logic [32*NI-1:0]    eng_second_row,
  output logic                eng_read_now,
  input  logic                eng_finish,
  input  logic [31:0]         eng_result,
  output logic                res_valid,
  output logic [31:0]         res_data,
  output logic [ROW_W-1:0]    res_index,
  input  logic                res_ready,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned CW = cnt_width(MEM_LAT, RST_CYCLES, TIMEOUT);

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_num_rows;
  logic [ADDR_W-1:0]   r_base;

  logic                w_tmr_load;
  logic                w_tmr_dec;
  logic [CW-1:0]       w_tmr_val;
  logic                w_tmr_zero;
  logic [ROW_W-1:0]    w_next_row;
  logic                w_last_row;

  assign w_next_row = r_row + ROW_W'(1);
  assign w_last_row = (r_row == (r_num_rows - ROW_W'(1)));

  // One timer serves memory latency, engine-reset hold and finish timeout;
  // each load is value-1 so the state lasts exactly that many cycles
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_dec  = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_FETCH: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(MEM_LAT - 1);
      end
      S_WAIT_MEM: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CW'(RST_CYCLES - 1);
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_ENG_RST:  w_tmr_dec = !w_tmr_zero;
      S_LAUNCH: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(TIMEOUT - 1);
      end
      S_WAIT_FIN: w_tmr_dec = !eng_finish && !w_tmr_zero;
      default: ;
    endcase
  end

  dot_feeder_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Main sequencer; every output is registered and set on the transition
  // into the state that owns it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_num_rows     <= '0;
      r_base         <= '0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      eng_reset      <= 1'b1;
      eng_read_now   <= 1'b0;
      eng_first_row  <= '0;
      eng_second_row <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_index      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done         <= 1'b0;
      mem_rd_en    <= 1'b0;
      eng_read_now <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_rows == '0) begin
              done <= 1'b1;
            end else begin
              r_num_rows     <= num_rows;
              r_base         <= base_addr;
              eng_second_row <= vector_in;
              r_row          <= '0;
              error          <= 1'b0;
              busy           <= 1'b1;
              mem_rd_en      <= 1'b1;
              mem_addr       <= base_addr;
              eng_reset      <= 1'b0;
              r_state        <= S_FETCH;
            end
          end
        end
        S_FETCH: r_state <= S_WAIT_MEM;
        S_WAIT_MEM: begin
          if (w_tmr_zero) begin
            eng_first_row <= mem_rd_data;
            eng_reset     <= 1'b1;
            r_state       <= S_ENG_RST;
          end
        end
        S_ENG_RST: begin
          if (w_tmr_zero) begin
            eng_reset    <= 1'b0;
            eng_read_now <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT_FIN;
        S_WAIT_FIN: begin
          if (eng_finish) begin
            res_data  <= eng_result;
            res_index <= r_row;
            res_valid <= 1'b1;
            r_state   <= S_OUTPUT;
          end else if (w_tmr_zero) begin
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            eng_reset <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (w_last_row) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              eng_reset <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_row     <= w_next_row;
              mem_addr  <= r_base + ADDR_W'(w_next_row);
              mem_rd_en <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Directed bench for dot_product_row_feeder with a behavioural row memory
// (latency 1) and a behavioural float32 dot-product engine (latency 12).
module tb_dot_product_row_feeder;
  import dot_feeder_pkg::*;

  localparam int NI = 8, ADDR_W = 10, ROW_W = 10;
  localparam int MEM_LAT = 1, RST_CYCLES = 2, TIMEOUT = 64, ENG_LAT = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  num_rows = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [32*NI-1:0]  vector_in = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [32*NI-1:0]  mem_rd_data = '0;
  logic              eng_reset;
  logic [32*NI-1:0]  eng_first_row, eng_second_row;
  logic              eng_read_now;
  logic              eng_finish = 1'b0;
  logic [31:0]       eng_result = '0;
  logic              res_valid;
  logic [31:0]       res_data;
  logic [ROW_W-1:0]  res_index;
  logic              res_ready = 1'b0;
  logic              busy, done, error;

  int checks = 0;
  int failures = 0;

  dot_product_row_feeder #(
    .NI(NI), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
    .MEM_LAT(MEM_LAT), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .base_addr(base_addr), .vector_in(vector_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .eng_reset(eng_reset), .eng_first_row(eng_first_row),
    .eng_second_row(eng_second_row), .eng_read_now(eng_read_now),
    .eng_finish(eng_finish), .eng_result(eng_result),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .res_ready(res_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // ---------------- float helpers (via double-precision bits) -------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] dot(input logic [32*NI-1:0] a,
                                      input logic [32*NI-1:0] b);
    real s;
    s = 0.0;
    for (int i = 0; i < NI; i++) s += f2r(a[32*i +: 32]) * f2r(b[32*i +: 32]);
    return r2f(s);
  endfunction

  function automatic logic [32*NI-1:0] splat(input logic [31:0] v);
    logic [32*NI-1:0] r;
    for (int i = 0; i < NI; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  // ---------------- row memory, latency 1 ---------------------------------
  logic [32*NI-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // ---------------- behavioural engine ------------------------------------
  bit eng_hang = 1'b0;
  bit eng_run = 1'b0;
  int eng_cnt = 0;

  always @(posedge clk) begin
    if (eng_reset) begin
      eng_finish <= 1'b0;
      eng_run    <= 1'b0;
    end else if (eng_read_now) begin
      eng_run    <= 1'b1;
      eng_cnt    <= ENG_LAT - 1;
      eng_result <= dot(eng_first_row, eng_second_row);
    end else if (eng_run && !eng_hang) begin
      if (eng_cnt <= 1) begin
        eng_finish <= 1'b1;
        eng_run    <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // ---------------- passive monitors --------------------------------------
  logic [ADDR_W-1:0] addr_log [$];
  int rd_count = 0, done_cnt = 0, valid_cnt = 0;
  int rst_run = 0, rst_min = 1000, rst_max = 0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      addr_log.push_back(mem_addr);
      rd_count++;
    end
    if (done) done_cnt++;
    if (res_valid) valid_cnt++;
    if (eng_read_now) begin
      if (rst_run < rst_min) rst_min = rst_run;
      if (rst_run > rst_max) rst_max = rst_run;
    end
    if (eng_reset) rst_run++;
    else rst_run = 0;
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ROW_W-1:0] n, input logic [ADDR_W-1:0] b,
                          input logic [32*NI-1:0] v);
    num_rows  = n;
    base_addr = b;
    vector_in = v;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if ({mem_rd_en, eng_read_now, res_valid, busy, done, error} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000",
        {mem_rd_en, eng_read_now, res_valid, busy, done, error});
    end
    checks++; if (eng_reset !== 1'b1) begin
      failures++; $display("FAIL reset_eng_reset: got %b expected 1", eng_reset);
    end
    checks++; if ({mem_addr, res_data, res_index} !== '0) begin
      failures++; $display("FAIL reset_regs: addr %h data %h idx %h expected 0",
        mem_addr, res_data, res_index);
    end
    checks++; if ({eng_first_row, eng_second_row} !== '0) begin
      failures++; $display("FAIL reset_operands: got nonzero expected 0");
    end
    reset = 1'b0;
    tick();
    checks++; if ({busy, eng_reset} !== 2'b01) begin
      failures++; $display("FAIL idle_after_reset: busy,eng_reset %b expected 01",
        {busy, eng_reset});
    end
  endtask

  task automatic test_single();
    int w;
    do_start(ROW_W'(1), ADDR_W'(5), splat(FP_TWO));
    checks++; if ({busy, mem_rd_en, mem_addr} !== {2'b11, ADDR_W'(5)}) begin
      failures++; $display("FAIL single_fetch: busy %b rd %b addr %0d expected 1 1 5",
        busy, mem_rd_en, mem_addr);
    end
    w = 0;
    while (!res_valid && w < 100) begin tick(); w++; end
    // FETCH is cycle 1; 1+MEM_LAT+RST+1+ENG_LAT+1 puts res_valid at cycle 18
    checks++; if (w !== 17) begin
      failures++; $display("FAIL single_latency: got %0d cycles expected 17", w);
    end
    checks++; if ({res_valid, res_data, res_index} !== {1'b1, FP_SIXTEEN, ROW_W'(0)}) begin
      failures++; $display("FAIL single_result: valid %b data %h idx %0d expected 1 41800000 0",
        res_valid, res_data, res_index);
    end
    checks++; if ({eng_first_row, eng_second_row} !== {splat(FP_ONE), splat(FP_TWO)}) begin
      failures++; $display("FAIL single_operands: row %h vec %h",
        eng_first_row[31:0], eng_second_row[31:0]);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if ({res_valid, done, busy} !== 3'b010) begin
      failures++; $display("FAIL single_done: valid,done,busy %b expected 010",
        {res_valid, done, busy});
    end
    tick();
    checks++; if (done !== 1'b0) begin
      failures++; $display("FAIL single_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    int w;
    int base_sz;
    logic [31:0]       exp_d [0:2];
    logic [ADDR_W-1:0] exp_a [0:2];
    exp_d[0] = 32'h41900000; exp_d[1] = 32'h42000000; exp_d[2] = 32'h43800000;
    exp_a[0] = ADDR_W'(1022); exp_a[1] = ADDR_W'(1023); exp_a[2] = ADDR_W'(0);
    base_sz = addr_log.size();
    res_ready = 1'b1;
    do_start(ROW_W'(3), ADDR_W'(1022), splat(FP_TWO));
    for (int r = 0; r < 3; r++) begin
      w = 0;
      while (!res_valid && w < 100) begin tick(); w++; end
      checks++; if ({res_valid, res_data, res_index} !== {1'b1, exp_d[r], ROW_W'(r)}) begin
        failures++; $display("FAIL wrap_row%0d: valid %b data %h idx %0d expected 1 %h %0d",
          r, res_valid, res_data, res_index, exp_d[r], r);
      end
      tick();
    end
    res_ready = 1'b0;
    checks++; if ({done, busy} !== 2'b10) begin
      failures++; $display("FAIL wrap_done: done,busy %b expected 10", {done, busy});
    end
    checks++; if (addr_log.size() - base_sz !== 3) begin
      failures++; $display("FAIL wrap_reads: got %0d expected 3", addr_log.size() - base_sz);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (addr_log[base_sz + k] !== exp_a[k]) begin
          failures++; $display("FAIL wrap_addr%0d: got %0d expected %0d",
            k, addr_log[base_sz + k], exp_a[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int w;
    int rd_snap;
    do_start(ROW_W'(2), ADDR_W'(5), splat(FP_TWO));
    w = 0;
    while (!res_valid && w < 100) begin tick(); w++; end
    checks++; if (res_valid !== 1'b1) begin
      failures++; $display("FAIL stall_first_valid: got %b expected 1", res_valid);
    end
    rd_snap = rd_count;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if ({res_valid, res_data, res_index} !== {1'b1, FP_SIXTEEN, ROW_W'(0)}) begin
        failures++; $display("FAIL stall_hold_c%0d: valid %b data %h idx %0d expected 1 41800000 0",
          c, res_valid, res_data, res_index);
      end
    end
    checks++; if (rd_count !== rd_snap) begin
      failures++; $display("FAIL stall_no_fetch: reads %0d expected %0d", rd_count, rd_snap);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    w = 0;
    while (!res_valid && w < 100) begin tick(); w++; end
    checks++; if ({res_valid, res_data, res_index} !== {1'b1, 32'h42000000, ROW_W'(1)}) begin
      failures++; $display("FAIL stall_second: valid %b data %h idx %0d expected 1 42000000 1",
        res_valid, res_data, res_index);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (done !== 1'b1) begin
      failures++; $display("FAIL stall_done: got %b expected 1", done);
    end
    checks++; if (rst_min !== RST_CYCLES || rst_max !== RST_CYCLES) begin
      failures++; $display("FAIL eng_reset_hold: min %0d max %0d expected %0d",
        rst_min, rst_max, RST_CYCLES);
    end
  endtask

  task automatic test_zero_rows();
    int rd_snap;
    rd_snap = rd_count;
    tick();
    do_start(ROW_W'(0), ADDR_W'(9), splat(FP_TWO));
    checks++; if ({done, busy} !== 2'b10) begin
      failures++; $display("FAIL zero_done: done,busy %b expected 10", {done, busy});
    end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL zero_after: done,busy %b expected 00", {done, busy});
    end
    checks++; if (rd_count !== rd_snap) begin
      failures++; $display("FAIL zero_no_read: reads %0d expected %0d", rd_count, rd_snap);
    end
  endtask

  task automatic test_timeout();
    int w;
    int valid_snap;
    valid_snap = valid_cnt;
    eng_hang = 1'b1;
    do_start(ROW_W'(1), ADDR_W'(5), splat(FP_TWO));
    w = 0;
    while (!eng_read_now && w < 50) begin tick(); w++; end
    checks++; if (eng_read_now !== 1'b1) begin
      failures++; $display("FAIL timeout_launch: got %b expected 1", eng_read_now);
    end
    w = 0;
    while (!error && w < 200) begin tick(); w++; end
    // 64 cycles in WAIT_FIN after the launch cycle, flag registered on the next
    checks++; if (w !== 65) begin
      failures++; $display("FAIL timeout_cycles: got %0d expected 65", w);
    end
    checks++; if ({error, done, busy} !== 3'b110) begin
      failures++; $display("FAIL timeout_flags: error,done,busy %b expected 110",
        {error, done, busy});
    end
    checks++; if (valid_cnt !== valid_snap) begin
      failures++; $display("FAIL timeout_no_valid: got %0d expected %0d", valid_cnt, valid_snap);
    end
    eng_hang = 1'b0;
    tick();
    checks++; if (error !== 1'b1) begin
      failures++; $display("FAIL error_sticky: got %b expected 1", error);
    end
    res_ready = 1'b1;
    do_start(ROW_W'(1), ADDR_W'(5), splat(FP_TWO));
    checks++; if (error !== 1'b0) begin
      failures++; $display("FAIL error_clear: got %b expected 0", error);
    end
    w = 0;
    while (!res_valid && w < 100) begin tick(); w++; end
    checks++; if ({res_valid, res_data} !== {1'b1, FP_SIXTEEN}) begin
      failures++; $display("FAIL timeout_recover: valid %b data %h expected 1 41800000",
        res_valid, res_data);
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    int base_sz;
    int done_snap;
    base_sz = addr_log.size();
    res_ready = 1'b1;
    do_start(ROW_W'(3), ADDR_W'(5), splat(FP_TWO));
    tick();
    num_rows  = ROW_W'(0);
    base_addr = ADDR_W'(100);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin
      failures++; $display("FAIL busy_start_ignored: busy,done %b expected 10", {busy, done});
    end
    seen = 0;
    w = 0;
    while (w < 200) begin
      tick(); w++;
      if (eng_read_now) begin
        seen++;
        if (seen == 2) break;
      end
    end
    checks++; if (seen !== 2) begin
      failures++; $display("FAIL mid_second_launch: got %0d launches expected 2", seen);
    end
    tick();
    checks++; if (addr_log.size() < base_sz + 2 || addr_log[base_sz + 1] !== ADDR_W'(6)) begin
      failures++; $display("FAIL mid_row1_addr: entries %0d expected addr 6",
        addr_log.size() - base_sz);
    end
    done_snap = done_cnt;
    reset = 1'b1;
    tick();
    checks++; if ({busy, eng_reset, done, res_valid, eng_read_now, mem_rd_en} !== 6'b010000) begin
      failures++; $display("FAIL mid_reset: busy,eng_reset,done,valid,launch,rd %b expected 010000",
        {busy, eng_reset, done, res_valid, eng_read_now, mem_rd_en});
    end
    reset = 1'b0;
    res_ready = 1'b0;
    repeat (5) tick();
    checks++; if (done_cnt !== done_snap || busy !== 1'b0) begin
      failures++; $display("FAIL mid_no_done: done pulses %0d expected %0d busy %b",
        done_cnt - done_snap, 0, busy);
    end
  endtask

  // ---------------- sequence ----------------------------------------------
  initial begin
    logic [32*NI-1:0] r;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    mem[5] = splat(FP_ONE);
    mem[6] = splat(FP_TWO);
    mem[7] = splat(FP_ONE);
    r = splat(FP_ONE);
    r[31:0] = FP_TWO;
    mem[1022] = r;
    mem[1023] = splat(FP_TWO);
    mem[0] = splat(FP_SIXTEEN);

    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_zero_rows();
    test_timeout();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
